// File: rtl/spi_master_mc_pkg.sv
// Shared definitions for the multi-slave SPI master (and the future SPI slave).
//   state_t   : frame sequencer states
//   MODE_*    : bit positions inside the latched {cpol, cpha} mode vector
package spi_master_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned MODE_CPHA = 0;
  localparam int unsigned MODE_CPOL = 1;

endpackage

// File: rtl/spi_master_mc_sck_div.sv
// SCK half-period divider: DIV_W down-counter, loaded on frame start and
// reloaded on every terminal count, giving a tick every div+1 enabled cycles.
//   clk, rst : clock, synchronous active-high reset
//   load     : load count with div (takes priority over en)
//   en       : count enable
//   div      : reload value (half-period minus one)
//   count    : current count value
//   tick_c   : combinational, high on the terminal-count cycle while enabled
module spi_master_mc_sck_div
  import spi_master_mc_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] count,
  output logic             tick_c
);

  assign tick_c = en && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= div;
    end else if (en) begin
      count <= tick_c ? div : count - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Parametrised multi-slave SPI master with start/busy/done host handshake,
// programmable SCK divider, all four CPOL/CPHA modes and MSB/LSB-first order.
//   clk, rst        : clock, synchronous active-high reset
//   start, tx_data  : transfer request and word to send
//   ss_sel          : slave index (ignored request if >= NUM_SS)
//   cpol, cpha      : SPI mode; lsb_first : bit order; clk_div : half-period - 1
//   busy, done      : frame in progress / one-cycle completion pulse
//   rx_data         : received word, valid from done
//   sck, mosi, miso : SPI pins; ssn : active-low selects
module spi_master_mc
  import spi_master_mc_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned NUM_SS = 8,
  parameter  int unsigned DIV_W  = 8,
  localparam int unsigned SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ssn
);

  localparam int unsigned EDGES = 2 * DATA_W;
  localparam int unsigned EC_W  = $clog2(EDGES + 1);

  state_t              state;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic [EC_W-1:0]     edge_cnt;
  logic [MODE_W-1:0]   mode;
  logic                lsb_l;
  logic [DIV_W-1:0]    div_l;
  logic [DIV_W-1:0]    div_c;
  logic [DIV_W-1:0]    count;
  logic                tick_c;
  logic                accept_c;
  logic                xfer_tick_c;
  logic [EC_W-1:0]     edge_next_c;
  logic                last_edge_c;
  logic                sample_c;
  logic                present_c;
  logic                finish_c;
  logic [DATA_W-1:0]   rx_shift_c;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign accept_c    = start && (state == ST_IDLE) && (32'(ss_sel) < NUM_SS);
  // Live divider on the accepting cycle, latched copy for every reload after.
  assign div_c       = accept_c ? clk_div : div_l;
  assign xfer_tick_c = (state == ST_XFER) && tick_c;
  assign edge_next_c = edge_cnt + EC_W'(1);
  assign last_edge_c = (edge_next_c == EC_W'(EDGES));

  // Odd edges are leading edges; CPHA picks which edge type samples.
  assign sample_c  = xfer_tick_c && (mode[MODE_CPHA] ? !edge_next_c[0] : edge_next_c[0]);
  assign present_c = xfer_tick_c && (mode[MODE_CPHA] ? edge_next_c[0]
                                                     : (!edge_next_c[0] && !last_edge_c));

  assign rx_shift_c = lsb_l ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};

  // done must be visible in the last TRAIL cycle, so finish one cycle early;
  // with H=1 that cycle is the one straight after the final XFER tick.
  assign finish_c = (xfer_tick_c && last_edge_c && (div_l == '0)) ||
                    ((state == ST_TRAIL) && (count == DIV_W'(1)));

  spi_master_mc_sck_div #(
    .DIV_W (DIV_W)
  ) u_sck_div (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_c),
    .en     (state != ST_IDLE),
    .div    (div_c),
    .count  (count),
    .tick_c (tick_c)
  );

  // Frame sequencer, shift registers and pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      ssn      <= '1;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      mode     <= '0;
      lsb_l    <= 1'b0;
      div_l    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sck <= cpol;
          ssn <= '1;
          if (accept_c) begin
            state    <= ST_LEAD;
            busy     <= 1'b1;
            ssn      <= ~(NUM_SS'(1) << ss_sel);
            mode     <= {cpol, cpha};
            lsb_l    <= lsb_first;
            div_l    <= clk_div;
            edge_cnt <= '0;
            rx_sr    <= '0;
            // CPHA=0 needs the first bit on the line before the first edge.
            if (cpha) begin
              tx_sr <= tx_data;
            end else begin
              mosi  <= first_bit(tx_data, lsb_first);
              tx_sr <= shift_out(tx_data, lsb_first);
            end
          end
        end
        ST_LEAD: begin
          if (tick_c) state <= ST_XFER;
        end
        ST_XFER: begin
          if (tick_c) begin
            sck      <= ~sck;
            edge_cnt <= edge_next_c;
            if (sample_c) rx_sr <= rx_shift_c;
            if (present_c) begin
              mosi  <= first_bit(tx_sr, lsb_l);
              tx_sr <= shift_out(tx_sr, lsb_l);
            end
            if (last_edge_c) state <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          sck <= mode[MODE_CPOL];
        end
        default: state <= ST_IDLE;
      endcase

      // ssn stays low through the done cycle and is released by IDLE next.
      if (finish_c) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        done    <= 1'b1;
        rx_data <= sample_c ? rx_shift_c : rx_sr;
      end
    end
  end

endmodule
